// File: rtl/wt_col_sched_if.sv
// Bundle between the layer controller / weight buffer and the column-skewed weight read scheduler.
interface wt_col_sched_if #(
    parameter int C  = 8,
    parameter int AW = 14,
    parameter int CW = 11
);
    logic            start;
    logic [CW-1:0]   len;
    logic [CW-1:0]   pass_num;
    logic [AW-1:0]   base_addr;
    logic [AW-1:0]   col_stride;
    logic [AW-1:0]   pass_stride;
    logic            hold;
    logic [C-1:0]    wt_vld;
    logic [C*AW-1:0] wt_addr;
    logic            busy;
    logic            done;

    modport master (
        output start, len, pass_num, base_addr, col_stride, pass_stride, hold,
        input  wt_vld, wt_addr, busy, done
    );

    modport slave (
        input  start, len, pass_num, base_addr, col_stride, pass_stride, hold,
        output wt_vld, wt_addr, busy, done
    );
endinterface

// File: rtl/wt_col_sched.sv
// Column-skewed weight read scheduler for the PE array.
// States: IDLE wait start | RUN issue column-0 reads | DRAIN flush the skew pipe | DONE done pulse
module wt_col_sched #(
    parameter int C  = 8,
    parameter int AW = 14,
    parameter int CW = 11
) (
    input logic           clk_cal,
    input logic           rst_cal,
    wt_col_sched_if.slave bus
);
    localparam int DW = (C > 2) ? $clog2(C) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_len;
    logic [CW-1:0]   r_pnum;
    logic [CW-1:0]   r_k;
    logic [CW-1:0]   r_p;
    logic [AW-1:0]   r_base;
    logic [AW-1:0]   r_cstr;
    logic [AW-1:0]   r_pstr;
    logic [AW-1:0]   r_off;
    logic [C-1:0]    r_sv;
    logic [C-1:0]    r_ovld;
    logic [AW-1:0]   r_addr [C];
    logic [DW-1:0]   r_dcnt;
    logic            r_busy;
    logic            r_done;

    logic            w_idle_start;
    logic            w_degen;
    logic            w_issue;
    logic            w_last_k;
    logic            w_last;
    logic            w_adv;
    logic [CW-1:0]   w_len;
    logic [CW-1:0]   w_pnum;
    logic [CW-1:0]   w_k;
    logic [CW-1:0]   w_p;
    logic [CW-1:0]   w_k_nx;
    logic [CW-1:0]   w_p_nx;
    logic [AW-1:0]   w_base;
    logic [AW-1:0]   w_pstr;
    logic [AW-1:0]   w_off;
    logic [AW-1:0]   w_off_nx;
    logic [AW-1:0]   w_addr0;
    logic [C-1:0]    w_nv;
    logic [AW-1:0]   w_na [C];
    logic [C*AW-1:0] w_addr_flat;

    // The accepting start edge is also the first issue, so column 0 is valid the very next cycle.
    always_comb begin
        w_idle_start = (r_state == S_IDLE) && bus.start;
        w_degen      = (bus.len == '0) || (bus.pass_num == '0);
        w_len        = (r_state == S_IDLE) ? bus.len         : r_len;
        w_pnum       = (r_state == S_IDLE) ? bus.pass_num    : r_pnum;
        w_base       = (r_state == S_IDLE) ? bus.base_addr   : r_base;
        w_pstr       = (r_state == S_IDLE) ? bus.pass_stride : r_pstr;
        w_k          = (r_state == S_IDLE) ? '0 : r_k;
        w_p          = (r_state == S_IDLE) ? '0 : r_p;
        w_off        = (r_state == S_IDLE) ? '0 : r_off;
        w_issue      = !bus.hold && ((w_idle_start && !w_degen) || (r_state == S_RUN));
        w_last_k     = (w_k == w_len - CW'(1));
        w_last       = w_last_k && (w_p == w_pnum - CW'(1));
        w_adv        = w_issue || ((r_state == S_DRAIN) && !bus.hold);
        w_addr0      = w_base + w_off + AW'(w_k);
        if (w_last_k) begin
            w_k_nx   = '0;
            w_p_nx   = w_p + CW'(1);
            w_off_nx = w_off + w_pstr;
        end else begin
            w_k_nx   = w_k + CW'(1);
            w_p_nx   = w_p;
            w_off_nx = w_off;
        end
    end

    always_comb begin
        w_nv    = {r_sv[C-2:0], w_issue};
        w_na[0] = w_addr0;
        for (int c = 1; c < C; c++) begin
            w_na[c] = r_addr[c-1] + r_cstr;
        end
        w_addr_flat = '0;
        for (int c = 0; c < C; c++) begin
            w_addr_flat[c*AW +: AW] = r_addr[c];
        end
    end

    always_ff @(posedge clk_cal) begin
        if (rst_cal) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_pnum  <= '0;
            r_k     <= '0;
            r_p     <= '0;
            r_base  <= '0;
            r_cstr  <= '0;
            r_pstr  <= '0;
            r_off   <= '0;
            r_sv    <= '0;
            r_ovld  <= '0;
            r_dcnt  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int c = 0; c < C; c++) begin
                r_addr[c] <= '0;
            end
        end else begin
            // r_sv keeps the logical pipe contents while hold blanks the visible enables.
            if (w_adv) begin
                r_sv   <= w_nv;
                r_ovld <= w_nv;
                for (int c = 0; c < C; c++) begin
                    if (w_nv[c]) begin
                        r_addr[c] <= w_na[c];
                    end
                end
            end else begin
                r_ovld <= '0;
            end

            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_len  <= bus.len;
                        r_pnum <= bus.pass_num;
                        r_base <= bus.base_addr;
                        r_cstr <= bus.col_stride;
                        r_pstr <= bus.pass_stride;
                        r_busy <= 1'b1;
                        if (w_degen) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_dcnt <= '0;
                            if (w_issue) begin
                                r_k     <= w_k_nx;
                                r_p     <= w_p_nx;
                                r_off   <= w_off_nx;
                                r_state <= w_last ? S_DRAIN : S_RUN;
                            end else begin
                                r_k     <= '0;
                                r_p     <= '0;
                                r_off   <= '0;
                                r_state <= S_RUN;
                            end
                        end
                    end
                end
                S_RUN: begin
                    if (w_issue) begin
                        r_k   <= w_k_nx;
                        r_p   <= w_p_nx;
                        r_off <= w_off_nx;
                        if (w_last) begin
                            r_state <= S_DRAIN;
                            r_dcnt  <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!bus.hold) begin
                        if (r_dcnt == DW'(C - 1)) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_dcnt <= r_dcnt + DW'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_done <= 1'b0;
                    if (!bus.hold) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.wt_vld  = r_ovld;
    assign bus.wt_addr = w_addr_flat;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
endmodule

// File: tb/tb_wt_col_sched.sv
// Directed bench for wt_col_sched: expected (column, address) reads are queued per job and popped as enables appear.
module tb_wt_col_sched;
    localparam int C  = 8;
    localparam int AW = 14;
    localparam int CW = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wt_col_sched_if #(.C(C), .AW(AW), .CW(CW)) bus ();
    wt_col_sched #(.C(C), .AW(AW), .CW(CW)) dut (.clk_cal(clk), .rst_cal(rst), .bus(bus));

    int vectors     = 0;
    int miscompares = 0;
    int unsigned sb_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int r, input int hlo, input int hhi, inout int n0);
        logic [31:0] got;
        logic [31:0] exp;
        for (int c = 0; c < C; c++) begin
            if (bus.wt_vld[c]) begin
                got = (32'(c) << 16) | 32'(bus.wt_addr[c*AW +: AW]);
                if (sb_q.size() == 0) exp = 32'hDEAD0000;
                else exp = sb_q.pop_front();
                check($sformatf("sb_c%0d_r%0d", c, r), got, exp);
                if (c == 0) n0++;
            end
        end
        if (r >= hlo && r <= hhi) check($sformatf("hold_vld_r%0d", r), 32'(bus.wt_vld), 32'h0);
    endtask

    // hlo..hhi: cycles whose enables must be blanked by hold; rst_at/restart_at: cycle to pulse reset/start (0 = none).
    task automatic run_job(input int L, input int P, input int base, input int cs, input int ps,
                           input int hlo, input int hhi, input int rst_at, input int restart_at,
                           input int exp_done, input int exp_n0);
        int n0 = 0;
        int r = 0;
        int seen = 0;
        int last_addr = 0;
        sb_q.delete();
        for (int t = 0; t < L * P + C - 1; t++) begin
            for (int c = 0; c < C; c++) begin
                int i;
                int a;
                i = t - c;
                if (i >= 0 && i < L * P) begin
                    a = (base + (i / L) * ps + (i % L) + c * cs) & 32'h3FFF;
                    sb_q.push_back(32'((c << 16) | a));
                    if (c == 0) last_addr = a;
                end
            end
        end
        @(negedge clk);
        bus.start       = 1'b1;
        bus.len         = CW'(L);
        bus.pass_num    = CW'(P);
        bus.base_addr   = AW'(base);
        bus.col_stride  = AW'(cs);
        bus.pass_stride = AW'(ps);
        bus.hold        = 1'b0;
        while (seen == 0 && r < 300) begin
            @(negedge clk);
            r++;
            bus.start = 1'b0;
            sample(r, hlo, hhi, n0);
            if (r == 1) check("busy_c1", 32'(bus.busy), 32'h1);
            if (rst_at > 0 && r == rst_at + 1) begin
                check("rst_vld", 32'(bus.wt_vld), 32'h0);
                check("rst_addr", (bus.wt_addr == '0) ? 32'h0 : 32'h1, 32'h0);
                check("rst_busy", 32'(bus.busy), 32'h0);
                check("rst_done", 32'(bus.done), 32'h0);
                rst = 1'b0;
                sb_q.delete();
                break;
            end
            if (bus.done) begin
                seen = 1;
                check("done_cycle", r, exp_done);
                check("busy_at_done", 32'(bus.busy), 32'h1);
            end
            bus.hold = (r >= hlo - 1 && r <= hhi - 1);
            if (r == restart_at) begin
                bus.start = 1'b1;
                bus.len   = CW'(2);
            end
            if (rst_at > 0 && r == rst_at) rst = 1'b1;
        end
        if (rst_at == 0) begin
            check("done_seen", seen, 1);
            check("n_col0", n0, exp_n0);
            check("sb_empty", sb_q.size(), 0);
            @(negedge clk);
            bus.start = 1'b0;
            bus.hold  = 1'b0;
            check("idle_vld", 32'(bus.wt_vld), 32'h0);
            check("idle_busy", 32'(bus.busy), 32'h0);
            check("idle_done", 32'(bus.done), 32'h0);
            if (L * P > 0) check("addr_hold_c0", 32'(bus.wt_addr[AW-1:0]), last_addr);
            @(negedge clk);
            check("idle_busy2", 32'(bus.busy), 32'h0);
        end else begin
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.hold  = 1'b0;
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.len         = '0;
        bus.pass_num    = '0;
        bus.base_addr   = '0;
        bus.col_stride  = '0;
        bus.pass_stride = '0;
        bus.hold        = 1'b0;
        rst             = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_vld", 32'(bus.wt_vld), 32'h0);
        check("reset_addr", (bus.wt_addr == '0) ? 32'h0 : 32'h1, 32'h0);
        check("reset_busy", 32'(bus.busy), 32'h0);
        check("reset_done", 32'(bus.done), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        run_job(4, 1, 'h10,   'h100, 'h0,  0, -1, 0, 0, 12, 4);
        run_job(3, 2, 'h10,   'h100, 'h20, 0, -1, 0, 0, 14, 6);
        run_job(4, 1, 'h10,   'h100, 'h0,  3,  5, 0, 0, 15, 4);
        run_job(4, 1, 'h3FFE, 'h100, 'h0,  0, -1, 0, 0, 12, 4);
        run_job(0, 3, 'h10,   'h100, 'h0,  0, -1, 0, 1,  1, 0);
        run_job(8, 1, 'h40,   'h10,  'h0,  0, -1, 0, 3, 16, 8);
        run_job(4, 1, 'h10,   'h100, 'h0,  0, -1, 5, 0,  0, 0);
        run_job(4, 1, 'h10,   'h100, 'h0,  0, -1, 0, 0, 12, 4);
        run_job(5, 0, 'h10,   'h100, 'h0,  0, -1, 0, 0,  1, 0);
        run_job(2, 3, 'h3FF0, 'h7FF, 'h9,  4,  6, 0, 0, 17, 6);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
